// File: rtl/bisr_pkg.sv
// Shared types and helpers for the BISR fault-map path.
package bisr_pkg;

    // Default PE array dimension used across the BISR blocks.
    localparam int unsigned PE_DIM = 8;
    localparam int unsigned FLAT_W = PE_DIM * PE_DIM;

    // Fault-map controller states.
    typedef enum logic [1:0] {
        IDLE,
        PROG,
        LOAD,
        PUSH
    } state_e;

    // Base bit index of row r inside a flattened size x size map.
    function automatic int unsigned row_slice(input int unsigned r, input int unsigned size);
        return r * size;
    endfunction

endpackage

// File: rtl/fault_popcount.sv
// Combinational population count of the flattened fault map.
module fault_popcount #(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = 7
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    // Sum every set bit; synthesis builds the adder tree.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/envm_fault_map_ctrl.sv
// Owns the PE fault map: merges BIST rows into a shadow map, programs it into
// eNVM row by row, and at boot reads it back and delivers it to the weight allocator.
module envm_fault_map_ctrl
    import bisr_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE = PE_DIM,
    parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int unsigned CNT_WIDTH     = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   bist_row_valid,
    input  logic [ADDR_WIDTH-1:0]                  bist_row_addr,
    input  logic [SYSTOLIC_SIZE-1:0]               bist_row_faults,
    input  logic                                   bist_done,
    input  logic                                   boot_start,
    output logic                                   nvm_req,
    output logic                                   nvm_we,
    output logic [ADDR_WIDTH-1:0]                  nvm_addr,
    output logic [SYSTOLIC_SIZE-1:0]               nvm_wdata,
    input  logic [SYSTOLIC_SIZE-1:0]               nvm_rdata,
    input  logic                                   nvm_ack,
    output logic                                   envm_wr_en,
    output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
    output logic                                   busy,
    output logic                                   map_valid,
    output logic [CNT_WIDTH-1:0]                   fault_count,
    output logic                                   bist_drop_err
);

    localparam int unsigned MAP_W = SYSTOLIC_SIZE * SYSTOLIC_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    row_q, row_d;
    logic [SYSTOLIC_SIZE-1:0] shadow_q [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE-1:0] shadow_d [SYSTOLIC_SIZE];
    logic                     map_valid_q, map_valid_d;
    logic [CNT_WIDTH-1:0]     fault_count_q, fault_count_d;
    logic                     drop_err_q, drop_err_d;
    logic [CNT_WIDTH-1:0]     pop_count;
    logic                     last_ack;

    // In PROG/LOAD the request is always up, so a raw ack is a real completion.
    assign last_ack = nvm_ack && (row_q == LAST_ROW);

    fault_popcount #(
        .W  (MAP_W),
        .CW (CNT_WIDTH)
    ) u_popcount (
        .bits  (envm_faulty_patterns_flat),
        .count (pop_count)
    );

    // Shadow map is presented flat at all times; the consumer samples on envm_wr_en.
    always_comb begin
        envm_faulty_patterns_flat = '0;
        for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
            envm_faulty_patterns_flat[row_slice(r, SYSTOLIC_SIZE) +: SYSTOLIC_SIZE] = shadow_q[r];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; boot_start has priority over bist_done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (boot_start) begin
                    state_d = LOAD;
                end else if (bist_done) begin
                    state_d = PROG;
                end
            end
            PROG, LOAD: begin
                if (last_ack) begin
                    state_d = PUSH;
                end
            end
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: row counter, shadow merge/load, status flags.
    always_comb begin
        row_d         = row_q;
        shadow_d      = shadow_q;
        map_valid_d   = map_valid_q;
        fault_count_d = fault_count_q;
        drop_err_d    = drop_err_q;
        unique case (state_q)
            IDLE: begin
                if (boot_start) begin
                    for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
                        shadow_d[r] = '0;
                    end
                    map_valid_d = 1'b0;
                    row_d       = '0;
                end else begin
                    if (bist_done) begin
                        row_d = '0;
                    end
                    // Faults are sticky: OR-merge, never clear.
                    if (bist_row_valid) begin
                        shadow_d[bist_row_addr] = shadow_q[bist_row_addr] | bist_row_faults;
                    end
                end
            end
            PROG, LOAD: begin
                if (nvm_ack) begin
                    if (state_q == LOAD) begin
                        shadow_d[row_q] = nvm_rdata;
                    end
                    row_d = last_ack ? '0 : row_q + 1'b1;
                end
            end
            PUSH: begin
                map_valid_d   = 1'b1;
                fault_count_d = pop_count;
            end
            default: ;
        endcase
        // A BIST row arriving while busy is lost; flag it.
        if (state_q != IDLE && bist_row_valid) begin
            drop_err_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= '0;
            map_valid_q   <= 1'b0;
            fault_count_q <= '0;
            drop_err_q    <= 1'b0;
            for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
                shadow_q[r] <= '0;
            end
        end else begin
            row_q         <= row_d;
            map_valid_q   <= map_valid_d;
            fault_count_q <= fault_count_d;
            drop_err_q    <= drop_err_d;
            for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
                shadow_q[r] <= shadow_d[r];
            end
        end
    end

    // Outputs decoded from state; request fields stay stable because row/shadow
    // only change on the ack edge.
    always_comb begin
        nvm_req    = 1'b0;
        nvm_we     = 1'b0;
        nvm_addr   = '0;
        nvm_wdata  = '0;
        envm_wr_en = 1'b0;
        unique case (state_q)
            PROG: begin
                nvm_req   = 1'b1;
                nvm_we    = 1'b1;
                nvm_addr  = row_q;
                nvm_wdata = shadow_q[row_q];
            end
            LOAD: begin
                nvm_req  = 1'b1;
                nvm_addr = row_q;
            end
            PUSH:    envm_wr_en = 1'b1;
            default: ;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign map_valid     = map_valid_q;
    assign fault_count   = fault_count_q;
    assign bist_drop_err = drop_err_q;

endmodule

// File: tb/tb_envm_fault_map_ctrl.sv
// Scoreboard bench for envm_fault_map_ctrl with a behavioural eNVM and map model.
module tb_envm_fault_map_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 7;
    localparam int unsigned FW = N * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          bist_row_valid = 1'b0;
    logic [AW-1:0] bist_row_addr = '0;
    logic [N-1:0]  bist_row_faults = '0;
    logic          bist_done = 1'b0;
    logic          boot_start = 1'b0;
    logic          nvm_req, nvm_we, nvm_ack;
    logic [AW-1:0] nvm_addr;
    logic [N-1:0]  nvm_wdata, nvm_rdata;
    logic          envm_wr_en, busy, map_valid, bist_drop_err;
    logic [FW-1:0] flat;
    logic [CW-1:0] fault_count;

    always #5 clk = ~clk;

    envm_fault_map_ctrl dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .bist_row_valid            (bist_row_valid),
        .bist_row_addr             (bist_row_addr),
        .bist_row_faults           (bist_row_faults),
        .bist_done                 (bist_done),
        .boot_start                (boot_start),
        .nvm_req                   (nvm_req),
        .nvm_we                    (nvm_we),
        .nvm_addr                  (nvm_addr),
        .nvm_wdata                 (nvm_wdata),
        .nvm_rdata                 (nvm_rdata),
        .nvm_ack                   (nvm_ack),
        .envm_wr_en                (envm_wr_en),
        .envm_faulty_patterns_flat (flat),
        .busy                      (busy),
        .map_valid                 (map_valid),
        .fault_count               (fault_count),
        .bist_drop_err             (bist_drop_err)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [N-1:0]  wdata;
    } acc_t;

    typedef struct packed {
        logic [FW-1:0] flat;
        logic [CW-1:0] cnt;
    } del_t;

    acc_t exp_acc[$];
    del_t exp_del[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- eNVM environment model ----------------
    logic [N-1:0] mem [N];
    logic [N-1:0] img [N];
    logic         load_mem = 1'b0;
    int unsigned  max_delay = 0;
    int unsigned  wait_cnt, wait_tgt;
    logic         spur;

    assign nvm_ack   = nvm_req ? (wait_cnt >= wait_tgt) : spur;
    assign nvm_rdata = mem[nvm_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            wait_tgt <= 0;
            spur     <= 1'b0;
        end else begin
            spur <= (max_delay != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            if (nvm_req && nvm_ack) begin
                wait_cnt <= 0;
                wait_tgt <= $urandom_range(max_delay, 0);
            end else if (nvm_req) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (rst_n && nvm_req && nvm_ack && nvm_we) begin
            mem[nvm_addr] <= nvm_wdata;
        end
    end

    // ---------------- reference model of the fault map ----------------
    logic [N-1:0] ref_map [N];

    function automatic logic [FW-1:0] ref_flat();
        logic [FW-1:0] f = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) f[r*N+c] = ref_map[r][c];
        return f;
    endfunction

    function automatic logic [CW-1:0] ref_pop();
        int n = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) n += int'(ref_map[r][c]);
        return CW'(n);
    endfunction

    task automatic ref_commit();
        for (int r = 0; r < N; r++)
            exp_acc.push_back(acc_t'{we: 1'b1, addr: AW'(r), wdata: ref_map[r]});
        exp_del.push_back(del_t'{flat: ref_flat(), cnt: ref_pop()});
    endtask

    task automatic ref_boot();
        for (int r = 0; r < N; r++) begin
            ref_map[r] = mem[r];
            exp_acc.push_back(acc_t'{we: 1'b0, addr: AW'(r), wdata: '0});
        end
        exp_del.push_back(del_t'{flat: ref_flat(), cnt: ref_pop()});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          mon_prev_pend = 1'b0;
    acc_t          mon_prev;
    logic          mon_cnt_pend = 1'b0;
    logic [CW-1:0] mon_cnt_exp;
    acc_t          mon_a;
    del_t          mon_d;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_pend = 1'b0;
                mon_cnt_pend  = 1'b0;
            end else begin
                if (mon_cnt_pend) begin
                    check("fault_count", 64'(fault_count), 64'(mon_cnt_exp));
                    check("map_valid_after_push", 64'(map_valid), 64'd1);
                    mon_cnt_pend = 1'b0;
                end
                if (mon_prev_pend) begin
                    check("req_held_until_ack",
                          {52'd0, nvm_req, nvm_we, nvm_addr, nvm_we ? nvm_wdata : 8'h00},
                          {52'd0, 1'b1, mon_prev.we, mon_prev.addr,
                           mon_prev.we ? mon_prev.wdata : 8'h00});
                end
                if (nvm_req && nvm_ack) begin
                    if (exp_acc.size() == 0) begin
                        check("unexpected_access", 64'(nvm_addr), 64'hFFFF);
                    end else begin
                        mon_a = exp_acc.pop_front();
                        check("nvm_we", 64'(nvm_we), 64'(mon_a.we));
                        check("nvm_addr", 64'(nvm_addr), 64'(mon_a.addr));
                        if (mon_a.we) check("nvm_wdata", 64'(nvm_wdata), 64'(mon_a.wdata));
                    end
                end
                mon_prev_pend = nvm_req && !nvm_ack;
                mon_prev      = acc_t'{we: nvm_we, addr: nvm_addr, wdata: nvm_wdata};
                if (envm_wr_en) begin
                    if (exp_del.size() == 0) begin
                        check("unexpected_delivery", 64'(envm_wr_en), 64'd0);
                    end else begin
                        mon_d = exp_del.pop_front();
                        check("flat_map", flat, mon_d.flat);
                        mon_cnt_pend = 1'b1;
                        mon_cnt_exp  = mon_d.cnt;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs_zero(input string tag);
        check({tag, "_nvm_req"}, 64'(nvm_req), 64'd0);
        check({tag, "_nvm_we"}, 64'(nvm_we), 64'd0);
        check({tag, "_nvm_addr"}, 64'(nvm_addr), 64'd0);
        check({tag, "_nvm_wdata"}, 64'(nvm_wdata), 64'd0);
        check({tag, "_envm_wr_en"}, 64'(envm_wr_en), 64'd0);
        check({tag, "_flat"}, flat, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_map_valid"}, 64'(map_valid), 64'd0);
        check({tag, "_fault_count"}, 64'(fault_count), 64'd0);
        check({tag, "_drop_err"}, 64'(bist_drop_err), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bist_done = 1'b0;
        boot_start = 1'b0;
        bist_row_valid = 1'b0;
        exp_acc.delete();
        exp_del.delete();
        for (int r = 0; r < N; r++) ref_map[r] = '0;
        #1;
        check_outputs_zero(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_image();
        @(posedge clk);
        #1;
        load_mem = 1'b1;
        @(posedge clk);
        #1;
        load_mem = 1'b0;
    endtask

    task automatic bist_row(input int a, input logic [N-1:0] f);
        @(posedge clk);
        #1;
        bist_row_valid  = 1'b1;
        bist_row_addr   = AW'(a);
        bist_row_faults = f;
        ref_map[a]      = ref_map[a] | f;
        @(posedge clk);
        #1;
        bist_row_valid = 1'b0;
    endtask

    task automatic launch(input logic done, input logic boot);
        @(posedge clk);
        #1;
        bist_done  = done;
        boot_start = boot;
    endtask

    // Cycle c = c-th clock after the launch cycle; returns -1 on timeout.
    task automatic wait_delivery(output int lat);
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            bist_done      = 1'b0;
            boot_start     = 1'b0;
            bist_row_valid = 1'b0;
            @(negedge clk);
            if (envm_wr_en) begin
                lat = c;
                break;
            end
        end
        check("delivery_seen", 64'(lat > 0), 64'd1);
    endtask

    int lat;
    int found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < N; r++) img[r] = '0;
        load_image();
        #2;
        do_reset("reset");

        // BIST merge then commit with zero-wait ack.
        bist_row(0, 8'h01);
        bist_row(0, 8'h10);
        bist_row(7, 8'hFF);
        ref_commit();
        launch(1'b1, 1'b0);
        wait_delivery(lat);
        check("prog_latency", 64'(lat), 64'(N + 1));

        // Boot load from a preloaded eNVM.
        do_reset("reset2");
        for (int r = 0; r < N; r++) img[r] = (r == 3) ? 8'h81 : 8'h00;
        load_image();
        ref_boot();
        launch(1'b0, 1'b1);
        wait_delivery(lat);
        check("boot_latency", 64'(lat), 64'(N + 1));

        // Random BIST content with random ack delays, commit then reload.
        max_delay = 5;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < int'($urandom_range(5, 1)); k++)
                bist_row(int'($urandom_range(N - 1, 0)), 8'($urandom) & 8'($urandom));
            ref_commit();
            launch(1'b1, 1'b0);
            wait_delivery(lat);
            ref_boot();
            launch(1'b0, 1'b1);
            wait_delivery(lat);
        end

        // Same-cycle boot_start + bist_done + bist_row_valid: LOAD wins, nothing dropped.
        ref_boot();
        launch(1'b1, 1'b1);
        bist_row_valid  = 1'b1;
        bist_row_addr   = 3'd1;
        bist_row_faults = 8'hFF;
        wait_delivery(lat);
        check("simul_no_drop_err", 64'(bist_drop_err), 64'd0);

        // BIST row while programming is dropped and flagged.
        ref_commit();
        launch(1'b1, 1'b0);
        @(posedge clk);
        #1;
        bist_done       = 1'b0;
        bist_row_valid  = 1'b1;
        bist_row_addr   = 3'd2;
        bist_row_faults = 8'h5A;
        wait_delivery(lat);
        check("drop_err_set", 64'(bist_drop_err), 64'd1);

        // Reset in the middle of LOAD at row 4, then a full reload.
        max_delay = 3;
        ref_boot();
        launch(1'b0, 1'b1);
        found = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            boot_start = 1'b0;
            @(negedge clk);
            if (c == 1) check("map_valid_cleared_by_boot", 64'(map_valid), 64'd0);
            if (nvm_req && !nvm_we && nvm_addr == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("reached_load_row4", 64'(found), 64'd1);
        #1;
        do_reset("midload");
        ref_boot();
        launch(1'b0, 1'b1);
        wait_delivery(lat);

        repeat (3) @(posedge clk);
        check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
        check("del_queue_drained", 64'(exp_del.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
